// File: rtl/sysid_regs.sv
// System-identification and housekeeping register block: ID, build timestamp,
// scratch, control/status, 64-bit uptime with coherent snapshot, capabilities
// and externally driven user words on an Avalon-MM slave.
module sysid_regs #(
  parameter logic [31:0] SYS_ID    = 32'h5E22_01DE,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter int unsigned NUM_USER  = 4,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     read,
  input  logic                     write,
  input  logic [31:0]              writedata,
  input  logic [3:0]               byteenable,
  output logic [31:0]              readdata,
  output logic                     readdatavalid,
  input  logic [32*NUM_USER-1:0]   user_data
);

  localparam int unsigned NUM_WORDS = 8 + NUM_USER;
  localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TS      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_CAPS    = ADDR_W'(6);
  localparam logic [15:0]       PRE_MAX   = 16'(TICK_DIV - 1);
  localparam logic [31:0]       CAPS      = {16'h0002, 8'(TICK_DIV - 1), 8'(NUM_USER)};

  logic [31:0] scratch, scratch_next;
  logic        freeze, freeze_next;
  logic        err, err_next;
  logic [63:0] uptime, uptime_next, up_inc;
  logic [15:0] prescaler, prescaler_next;
  logic [31:0] snap_hi;
  logic        rdv_q;
  logic [31:0] rd_word;
  logic        addr_ok, wr_ok, tick, clr;
  logic        wr_scratch, wr_ctrl, wr_lo, wr_hi;

  // Read mux and write-permission decode from the pre-write register values
  always_comb begin
    rd_word = '0;
    wr_ok   = 1'b0;
    addr_ok = 32'(address) < NUM_WORDS;
    case (address)
      A_ID:      rd_word = SYS_ID;
      A_TS:      rd_word = TIMESTAMP;
      A_SCRATCH: begin rd_word = scratch; wr_ok = 1'b1; end
      A_CTRL:    begin rd_word = {23'd0, err, 6'd0, freeze, 1'b0}; wr_ok = 1'b1; end
      A_UP_LO:   begin rd_word = uptime[31:0]; wr_ok = 1'b1; end
      A_UP_HI:   begin rd_word = snap_hi; wr_ok = 1'b1; end
      A_CAPS:    rd_word = CAPS;
      default:   rd_word = '0;
    endcase
    for (int k = 0; k < int'(NUM_USER); k++) begin
      if (32'(address) == 32'(8 + k)) rd_word = user_data[32*k +: 32];
    end
  end

  // Next-state logic for writable registers, error flag and uptime counter
  always_comb begin
    wr_scratch = write && (address == A_SCRATCH);
    wr_ctrl    = write && (address == A_CTRL);
    wr_lo      = write && (address == A_UP_LO);
    wr_hi      = write && (address == A_UP_HI);
    clr        = wr_ctrl && writedata[0];

    scratch_next = scratch;
    for (int b = 0; b < 4; b++) begin
      if (wr_scratch && byteenable[b]) scratch_next[8*b +: 8] = writedata[8*b +: 8];
    end

    freeze_next = wr_ctrl ? writedata[1] : freeze;
    // a new error in the same cycle as a W1C clear leaves the flag set
    err_next = (err && !(wr_ctrl && writedata[8]))
             || (read && !addr_ok) || (write && !wr_ok);

    tick           = !freeze && (prescaler == PRE_MAX);
    up_inc         = uptime + 64'(tick);
    prescaler_next = freeze ? prescaler : (tick ? 16'd0 : prescaler + 16'd1);
    uptime_next    = up_inc;
    if (wr_lo) uptime_next[31:0]  = writedata;
    if (wr_hi) uptime_next[63:32] = writedata;
    if (clr) begin
      uptime_next    = '0;
      prescaler_next = '0;
    end
  end

  // Register state and the one-cycle read response
  always_ff @(posedge clock) begin
    if (reset) begin
      scratch   <= '0;
      freeze    <= 1'b0;
      err       <= 1'b0;
      uptime    <= '0;
      prescaler <= '0;
      snap_hi   <= '0;
      readdata  <= '0;
      rdv_q     <= 1'b0;
    end else begin
      scratch   <= scratch_next;
      freeze    <= freeze_next;
      err       <= err_next;
      uptime    <= uptime_next;
      prescaler <= prescaler_next;
      rdv_q     <= read;
      if (read) readdata <= rd_word;
      if (read && (address == A_UP_LO)) snap_hi <= uptime[63:32];
    end
  end

  // A response due while reset is asserted is dropped
  assign readdatavalid = rdv_q && !reset;

endmodule
